// File: rtl/i2c_controller.sv
// Byte-level I2C initiator: START / WRITE / READ / STOP commands with target clock stretching.
// Define I2C_CONTROLLER_ARB_LOST_EN to add arbitration-loss detection and abort.
module i2c_controller #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       ack_en,
  output logic       rsp_valid,
  output logic [7:0] rx_data,
  output logic       rx_nack,
  output logic       arb_lost,
  output logic       busy,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StBit    = 3'd2;
  localparam logic [2:0] StAckBit = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  localparam logic [7:0] QEnd = 8'(CLK_DIV - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic       rd_q, rd_d;
  logic [6:0] tx_q, tx_d;
  logic       ack_q, ack_d;
  logic [7:0] sh_q, sh_d;
  logic       nack_q, nack_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       rsp_q, rsp_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_nack_q, rx_nack_d;
  logic       busy_q, busy_d;

  // While SCL is released the quarter only advances once the line is actually high.
  logic count_en, tick;
  assign count_en = !(scl_q && !scl_i);
  assign tick     = count_en && (cnt_q == QEnd);

`ifdef I2C_CONTROLLER_ARB_LOST_EN
  logic arb_q, arb_d;
  logic abort;
  assign abort = sda_q && !sda_i &&
                 ((state_q == StStart && (qtr_q == 2'd1 || qtr_q == 2'd2)) ||
                  (state_q == StBit && !rd_q && tick && qtr_q == 2'd2));
  assign arb_lost = arb_q;
`else
  assign arb_lost = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    rd_d      = rd_q;
    tx_d      = tx_q;
    ack_d     = ack_q;
    sh_d      = sh_q;
    nack_d    = nack_q;
    scl_d     = scl_q;
    sda_d     = sda_q;
    rsp_d     = 1'b0;
    rx_data_d = rx_data_q;
    rx_nack_d = rx_nack_q;
    busy_d    = busy_q;

    if (state_q != StIdle && count_en) cnt_d = tick ? 8'd0 : cnt_q + 8'd1;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cnt_d = 8'd0;
          qtr_d = 2'd0;
          bit_d = 3'd0;
          case (cmd)
            3'd1: begin
              state_d = StStart;
              busy_d  = 1'b1;
              scl_d   = 1'b1;
              sda_d   = 1'b1;
            end
            3'd2: begin
              state_d = StBit;
              rd_d    = 1'b0;
              tx_d    = tx_data[6:0];
              scl_d   = 1'b0;
              sda_d   = tx_data[7];
            end
            3'd3: begin
              // All-ones shift pattern keeps SDA released through the data slots.
              state_d = StBit;
              rd_d    = 1'b1;
              tx_d    = 7'h7f;
              ack_d   = ack_en;
              scl_d   = 1'b0;
              sda_d   = 1'b1;
            end
            3'd4: begin
              state_d = StStop;
              scl_d   = 1'b0;
              sda_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StStart: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd1: sda_d = 1'b0;
            2'd2: scl_d = 1'b0;
            2'd3: begin
              state_d = StIdle;
              rsp_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StBit, StAckBit: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd1: scl_d = 1'b1;
            2'd2: begin
              if (state_q == StAckBit) nack_d = sda_i;
              else if (rd_q)           sh_d   = {sh_q[6:0], sda_i};
            end
            2'd3: begin
              scl_d = 1'b0;
              if (state_q == StAckBit) begin
                state_d = StIdle;
                rsp_d   = 1'b1;
                if (rd_q) rx_data_d = sh_q;
                else      rx_nack_d = nack_q;
              end else if (bit_q == 3'd7) begin
                state_d = StAckBit;
                sda_d   = rd_q ? ~ack_q : 1'b1;
              end else begin
                bit_d = bit_q + 3'd1;
                sda_d = tx_q[3'd6 - bit_q];
              end
            end
            default: ;
          endcase
        end
      end
      StStop: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd0: scl_d = 1'b1;
            2'd1: sda_d = 1'b1;
            2'd3: begin
              state_d = StIdle;
              rsp_d   = 1'b1;
              busy_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef I2C_CONTROLLER_ARB_LOST_EN
    arb_d = arb_q;
    if (state_q == StIdle && cmd_valid) arb_d = 1'b0;
    if (abort) begin
      state_d = StIdle;
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      rsp_d   = 1'b1;
      arb_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      qtr_q     <= 2'd0;
      cnt_q     <= 8'd0;
      bit_q     <= 3'd0;
      rd_q      <= 1'b0;
      tx_q      <= 7'h7f;
      ack_q     <= 1'b0;
      sh_q      <= 8'd0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      rsp_q     <= 1'b0;
      rx_data_q <= 8'd0;
      rx_nack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      rd_q      <= rd_d;
      tx_q      <= tx_d;
      ack_q     <= ack_d;
      sh_q      <= sh_d;
      nack_q    <= nack_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      rsp_q     <= rsp_d;
      rx_data_q <= rx_data_d;
      rx_nack_q <= rx_nack_d;
      busy_q    <= busy_d;
    end
  end

`ifdef I2C_CONTROLLER_ARB_LOST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_q <= 1'b0;
    else        arb_q <= arb_d;
  end
`endif

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = rsp_q;
  assign rx_data   = rx_data_q;
  assign rx_nack   = rx_nack_q;
  assign busy      = busy_q;
  assign scl_o     = scl_q;
  assign sda_o     = sda_q;

endmodule
